// File: rtl/sysbus_arbiter_if.sv
// Shared control/system bus bundle between the masters, the arbiter and the devices.
// The arbiter uses the slave view; a master/device model uses the master view.
interface sysbus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [2*NUM_REQ-1:0]      req_dev;
    logic [ADDR_W*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ldstr;
    logic [DATA_W*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic [1:0]                bus_dev;
    logic [ADDR_W-1:0]         bus_addr;
    logic                      bus_ldstr;
    logic [DATA_W-1:0]         bus_wdata;
    logic [DATA_W-1:0]         bus_rdata;

    modport slave (
        input  req, req_dev, req_addr, req_ldstr, req_wdata, bus_rdata,
        output gnt, done, rdata, bus_dev, bus_addr, bus_ldstr, bus_wdata
    );

    modport master (
        output req, req_dev, req_addr, req_ldstr, req_wdata, bus_rdata,
        input  gnt, done, rdata, bus_dev, bus_addr, bus_ldstr, bus_wdata
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter driving the shared system bus for one master at a time.
// Define SYSBUS_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins).
module sysbus_arbiter_chk #(
    parameter int NUM_REQ = 2
) (
    input logic               clk_i,
    input logic               rst_ni,
    input logic [NUM_REQ-1:0] gnt_i,
    input logic [NUM_REQ-1:0] done_i
);
    gnt_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_i));
    done_in_gnt_a: assert property (@(posedge clk_i) disable iff (!rst_ni) (done_i & ~gnt_i) == '0);
endmodule

module sysbus_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 1,
    parameter int ALU_WAIT = 0
) (
    input logic              clock_i,
    input logic              n_reset_i,
    sysbus_arbiter_if.slave  sys_bus
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int WAIT_W = 8;
    localparam logic [1:0] DEV_NONE = 2'b00;
    localparam logic [1:0] DEV_ROM  = 2'b01;
    localparam logic [1:0] DEV_RAM  = 2'b10;
    localparam logic [1:0] DEV_ALU  = 2'b11;
    localparam logic [NUM_REQ-1:0] ONE_R = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

    state_e              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          bus_dev_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic                bus_ldstr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic [WAIT_W-1:0]   wait_q;

    int                  base_s;
    logic                hit_s;
    logic                win_found_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic [1:0]          win_dev_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic                win_ldstr_s;
    logic [DATA_W-1:0]   win_wdata_s;

    function automatic logic [WAIT_W-1:0] wait_for_dev(input logic [1:0] dev);
        case (dev)
            DEV_ROM: wait_for_dev = WAIT_W'(ROM_WAIT);
            DEV_RAM: wait_for_dev = WAIT_W'(RAM_WAIT);
            DEV_ALU: wait_for_dev = WAIT_W'(ALU_WAIT);
            default: wait_for_dev = '0;
        endcase
    endfunction

`ifdef SYSBUS_ARB_FIXED_PRIORITY_EN
    assign base_s = 32'sd0;
`else
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] win_q;
    assign base_s = int'(rr_ptr_q);
`endif

    // Winner search: first set req starting at base_s, wrapping modulo NUM_REQ.
    always_comb begin
        hit_s       = 1'b0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        win_dev_s   = DEV_NONE;
        win_addr_s  = '0;
        win_ldstr_s = 1'b0;
        win_wdata_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                hit_s       = !win_found_s && (j == ((base_s + k) % NUM_REQ)) && sys_bus.req[j];
                win_idx_s   = hit_s ? IDX_W'(j) : win_idx_s;
                win_dev_s   = hit_s ? sys_bus.req_dev[2*j +: 2] : win_dev_s;
                win_addr_s  = hit_s ? sys_bus.req_addr[ADDR_W*j +: ADDR_W] : win_addr_s;
                win_ldstr_s = hit_s ? sys_bus.req_ldstr[j] : win_ldstr_s;
                win_wdata_s = hit_s ? sys_bus.req_wdata[DATA_W*j +: DATA_W] : win_wdata_s;
                win_found_s = win_found_s | hit_s;
            end
        end
    end

    // Arbitration FSM with all bus-facing outputs registered.
    always_ff @(posedge clock_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            bus_dev_q   <= DEV_NONE;
            bus_addr_q  <= '0;
            bus_ldstr_q <= 1'b0;
            bus_wdata_q <= '0;
            wait_q      <= '0;
`ifndef SYSBUS_ARB_FIXED_PRIORITY_EN
            rr_ptr_q    <= '0;
            win_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found_s) begin
                        bus_dev_q   <= win_dev_s;
                        bus_addr_q  <= win_addr_s;
                        bus_ldstr_q <= win_ldstr_s;
                        bus_wdata_q <= win_wdata_s;
                        gnt_q       <= ONE_R << win_idx_s;
                        wait_q      <= wait_for_dev(win_dev_s);
`ifndef SYSBUS_ARB_FIXED_PRIORITY_EN
                        win_q       <= win_idx_s;
`endif
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 1'b1;
                    end else begin
                        // A null device returns nothing, so only real loads update rdata.
                        if (!bus_ldstr_q && (bus_dev_q != DEV_NONE)) begin
                            rdata_q <= sys_bus.bus_rdata;
                        end
                        done_q  <= gnt_q;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus_dev_q <= DEV_NONE;
                    gnt_q     <= '0;
                    done_q    <= '0;
`ifndef SYSBUS_ARB_FIXED_PRIORITY_EN
                    rr_ptr_q  <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`endif
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sys_bus.gnt       = gnt_q;
    assign sys_bus.done      = done_q;
    assign sys_bus.rdata     = rdata_q;
    assign sys_bus.bus_dev   = bus_dev_q;
    assign sys_bus.bus_addr  = bus_addr_q;
    assign sys_bus.bus_ldstr = bus_ldstr_q;
    assign sys_bus.bus_wdata = bus_wdata_q;

    sysbus_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
        .clk_i  (clock_i),
        .rst_ni (n_reset_i),
        .gnt_i  (gnt_q),
        .done_i (done_q)
    );
endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single control bus / system bus (dev, opaddr, ldstr, data) between NUM_REQ masters, e.g. the instruction sequencer and an I/O or DMA engine.
- Masters post a complete transaction descriptor. The arbiter grants one master round-robin, drives the bus for a device-dependent number of wait cycles, captures read data and pulses a per-master done.
- Sits between the masters and the ROM/RAM/ALU devices. Devices see exactly one driver at a time.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..4); index 0 is the sequencer.
- DATA_W, 16, system bus data width.
- ADDR_W, 4, opaddr width.
- ROM_WAIT, 1, extra ACCESS cycles for dev = `ROM.
- RAM_WAIT, 1, extra ACCESS cycles for dev = `RAM.
- ALU_WAIT, 0, extra ACCESS cycles for dev = `ALU.

Ports:
- clock  in  1  system clock, all state on posedge.
- n_reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-master request level.
- req_dev  in  2*NUM_REQ  per-master target device code (control_sig.h encodings).
- req_addr  in  ADDR_W*NUM_REQ  per-master opaddr.
- req_ldstr  in  NUM_REQ  per-master load(0)/store(1).
- req_wdata  in  DATA_W*NUM_REQ  per-master write data.
- gnt  out  NUM_REQ  one-hot grant, high from grant through DONE.
- done  out  NUM_REQ  one-cycle completion pulse to the granted master.
- rdata  out  DATA_W  captured read data, shared by all masters.
- bus_dev  out  2  driven device code, 2'b00 = no device.
- bus_addr  out  ADDR_W  driven opaddr.
- bus_ldstr  out  1  driven load/store.
- bus_wdata  out  DATA_W  driven write data.
- bus_rdata  in  DATA_W  data returned by the device.

Behaviour:

Reset (async, n_reset low):
- state = IDLE; gnt, done = 0.
- bus_dev = 2'b00; bus_addr, bus_ldstr, bus_wdata = 0.
- rdata = 0; rr_ptr = 0; wait_cnt = 0.
- Reset mid-transaction abandons it; no done pulse is issued.

Master handshake:
- A master holds req high and its descriptor stable until it sees its done.
- It must deassert req in the cycle after done, or it is treated as a new request.
- If req drops mid-access, the access still completes and done still pulses. There is no abort.

FSM states: IDLE, ACCESS, DONE.

- IDLE:
  - If any req bit is set, select the winner: the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Register the winner's dev/addr/ldstr/wdata into the bus_* outputs, set gnt[winner], and load wait_cnt with the wait count for that dev. dev 2'b00 loads 0.
  - Next state: ACCESS.
  - With no req set, outputs hold their idle values.
- ACCESS:
  - Bus outputs are held constant.
  - If wait_cnt != 0: decrement it and stay in ACCESS.
  - If wait_cnt == 0: rdata <= bus_rdata when ldstr = 0, otherwise rdata is unchanged. Then done[winner] <= 1 and next state is DONE.
- DONE:
  - done is high for exactly this cycle; gnt is still high.
  - At the exit edge: bus_dev <= 2'b00, gnt <= 0, done <= 0, rr_ptr <= (winner + 1) mod NUM_REQ. Next state: IDLE.

Latency:
- From req sampled high in IDLE to the done pulse is W+2 cycles, where W is the wait count.
- Back-to-back transactions from different masters are spaced W+3 cycles apart.

Boundaries:
- Requests arriving during ACCESS/DONE wait until the next IDLE.
- All masters requesting simultaneously are served in rotating order starting at rr_ptr, so no master is starved.
- rr_ptr wraps from NUM_REQ-1 to 0.
- A descriptor with dev = 2'b00 is a legal no-op: W = 0, rdata is unchanged, done still pulses.
- Invalid one-hot on gnt is impossible by construction. An assertion checks $onehot0(gnt).

Optional Feature:
- Macro: SYSBUS_ARB_FIXED_PRIORITY_EN.
- Defined: winner selection is fixed priority, the lowest index wins, and rr_ptr is not implemented. The sequencer (index 0) always pre-empts other masters at each IDLE.
- Undefined: round-robin as described above.

Test Plan:
- Reset mid-ACCESS:
  - Stimulus: master0 RAM read, addr 4'h3, bus_rdata 16'hBEEF; n_reset pulsed low during ACCESS.
  - Response: gnt = 0 and bus_dev = 00 immediately, no done pulse; after release, the FSM returns to IDLE.
- Single master ROM read:
  - Stimulus: master0 req=1, dev `ROM, addr 4'h5, bus_rdata 16'h1234, ROM_WAIT = 1.
  - Response: gnt[0] on the next cycle, bus_addr = 5 for 2 cycles, done[0] 3 cycles after req, rdata = 16'h1234.
- Store:
  - Stimulus: master1 dev `RAM, ldstr = 1, addr 4'hA, wdata 16'h00FF.
  - Response: bus_wdata = 16'h00FF and bus_ldstr = 1 throughout ACCESS; rdata unchanged from its prior value; done[1] pulses once.
- Contention, round robin:
  - Stimulus: both masters hold req continuously.
  - Response: grants alternate 0,1,0,1; gnt is never 2'b11.
  - With SYSBUS_ARB_FIXED_PRIORITY_EN defined, master0 wins every IDLE.
- Null and ALU devices:
  - Stimulus: dev = 2'b00 request; then dev `ALU, ALU_WAIT = 0, bus_rdata 16'h0007.
  - Response: done 2 cycles after req in both cases; rdata unchanged after the null request, 16'h0007 after the ALU request.
- Req dropped mid-access:
  - Stimulus: master0 deasserts req during ACCESS with RAM_WAIT = 3.
  - Response: ACCESS still lasts 4 cycles; done[0] pulses; the next IDLE has no grant.
